// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, optional 2-entry skid
// buffer, synchronous flush and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int               WIDTH       = 64,
  parameter logic [WIDTH-1:0] BUBBLE      = {WIDTH{1'b0}},
  parameter bit               SKID        = 1'b1,
  parameter int               STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic             accept;
  logic             emit;

  // With the skid buffer, ready depends only on held state, cutting the
  // combinational out_ready -> in_ready path between stages.
  assign in_ready = SKID ? (!reset && !skid_valid)
                         : (!reset && (!out_valid || out_ready));

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_EMPTY;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= BUBBLE;
      skid_data  <= BUBBLE;
      stall_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + 1'b1;

      if (flush) begin
        state      <= ST_EMPTY;
        out_valid  <= 1'b0;
        skid_valid <= 1'b0;
        out_data   <= BUBBLE;
        skid_data  <= BUBBLE;
      end else begin
        unique case (state)
          ST_EMPTY: begin
            if (accept) begin
              out_data  <= in_data;
              out_valid <= 1'b1;
              state     <= ST_FULL;
            end
          end
          ST_FULL: begin
            if (accept && emit) begin
              out_data <= in_data;
            end else if (emit) begin
              out_valid <= 1'b0;
              state     <= ST_EMPTY;
            end else if (accept) begin
              // Only reachable with SKID=1; SKID=0 deasserts in_ready here.
              skid_data  <= in_data;
              skid_valid <= 1'b1;
              state      <= ST_SKID;
            end
          end
          ST_SKID: begin
            if (emit) begin
              out_data   <= skid_data;
              skid_valid <= 1'b0;
              state      <= ST_FULL;
            end
          end
          default: begin
            state      <= ST_EMPTY;
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
